combat_unit: RTL and testbench
==============================

# combat_unit

Parametrised lane combatant for the battle field: one instance is one unit slot, either player-side or enemy-side. It spawns on request with a type-dependent health/power profile and advances toward the opposing front on each movement tick. At the front it attacks on a cooldown, takes damage from the top-level resolver, and lingers in a timed dying state before its slot can be reused. The top level instantiates N of these per side and arbitrates `spawn_req`.

## Interface
- `POS_W`, default 9: position width; lane is 0 .. 2^POS_W-1.
- `HP_W`, default 8: health width.
- `DMG_W`, default 8: damage and power width.
- `DIR`, default 0: 0 means the unit advances upward (position increments, enemy side); 1 means it advances downward (player side).
- `SPAWN_POS`, default 0: lane position loaded at deploy.
- `ATK_COOLDOWN`, default 2: movement ticks skipped between attacks; 0 means attack every tick.
- `DEATH_HOLD`, default 4: number of clk cycles spent in DYING.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `spawn_req` in 1: request to occupy this slot.
- `spawn_type` in 2: 1..3 select a profile; 0 is ignored.
- `spawn_ack` out 1: one-cycle pulse when a request is accepted.
- `move_en` in 1: movement/attack tick, one-cycle strobe.
- `damage_en` in 1: apply `damage_in` this cycle.
- `damage_in` in DMG_W: incoming damage.
- `front_pos` in POS_W: position of the opposing frontmost unit.
- `position` out POS_W: current position.
- `damage_out` out DMG_W: attack value; nonzero for exactly one cycle per attack.
- `unit_type` out 2: current type; 0 when the slot is free.
- `alive` out 1: high in ALIVE.
- `dead` out 1: high in IDLE only.

## Operation
States: IDLE, DEPLOY, ALIVE, DYING. All outputs are registered.

- **IDLE**
  - `dead`=1, `alive`=0, `unit_type`=0, `damage_out`=0.
  - `spawn_req` with `spawn_type`≠0: pulse `spawn_ack`, latch the type, go to DEPLOY.
  - `spawn_type`=0: no ack, stay in IDLE.
- **DEPLOY** (1 cycle)
  - Load health and power from the package profile table.
  - `position`=SPAWN_POS, cooldown=0, `dead`=0.
  - Go to ALIVE.
- **ALIVE**
  - Damage
    - `damage_en` with `damage_in` ≥ health: health=0, go to DYING.
    - Otherwise health -= `damage_in`. Health never wraps.
  - `move_en` when the path is clear (DIR=0: `position` < `front_pos`; DIR=1: `position` > `front_pos`)
    - Step `position` ±1, saturating at 2^POS_W-1 or 0.
    - `damage_out`=0; cooldown unchanged.
  - `move_en` when blocked
    - cooldown==0: `damage_out`=power for one cycle, cooldown=ATK_COOLDOWN.
    - Otherwise `damage_out`=0 and cooldown decrements.
  - Lethal damage takes priority over a simultaneous `move_en`: no move, no attack.
  - Non-lethal damage and `move_en` in the same cycle both take effect.
- **DYING**
  - `alive`=0, `dead`=0; `unit_type` and `position` are held for the death animation.
  - Count DEATH_HOLD cycles, then go to IDLE.
  - `spawn_req`, `move_en` and `damage_en` are ignored.
- `spawn_req` outside IDLE is ignored, with no ack.

## Timing
- Reset values: state IDLE, `position`=0, `damage_out`=0, `unit_type`=0, `alive`=0, `dead`=1, `spawn_ack`=0, health=0, cooldown=0.
- Spawn latency: request at edge n gives `spawn_ack` after edge n, DEPLOY during n+1, and `alive`=1 after edge n+2.
- `damage_out` is asserted the cycle after the accepting `move_en` edge and clears on the next edge.
- Death: lethal hit at edge n gives `alive`=0 after n. `dead`=1 comes DEATH_HOLD+1 edges after the lethal hit.
- Reset asserted mid-operation returns to reset values immediately (asynchronous).
- Widths: comparisons are unsigned.

## Structure
- Shared package `battle_pkg` holds:
  - state encoding;
  - unit type codes;
  - the profile table, with per-type health = all ones of HP_W, and power = 2^(DMG_W-3), 2^(DMG_W-2), 2^(DMG_W-1) for types 1, 2, 3.
- The package is shared with the player-side instances and the top-level damage resolver.
- No sub-module; one FSM with health, cooldown and hold counters.

## Test plan
All scenarios use default parameters.
- Reset, then `spawn_req` with `spawn_type`=2 → `spawn_ack` 1 cycle; `alive`=1 two edges later; health 255; `position`=0; `unit_type`=2.
- `front_pos`=3 and 5 `move_en` strobes → `position` 1, 2, 3, then blocked; attack on the 4th strobe with `damage_out`=64 for one cycle; 5th strobe gives 0 (cooldown).
- Blocked unit, 7 `move_en` strobes → `damage_out`=64 on strobes 1, 4 and 7 only.
- `damage_in`=100 twice → health 155, then 55. A third hit of 55 in the same cycle as `move_en` → DYING, no attack. `dead`=1 exactly 5 edges after the hit.
- `spawn_req` in ALIVE or DYING, or with `spawn_type`=0 → no `spawn_ack`, state unchanged.
- DIR=1, SPAWN_POS=511, `front_pos`=509 → `position` 510, 509, then attack. `reset` pulsed mid-walk → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/battle_pkg.sv
// Shared battle definitions: unit state encoding, unit type codes and the
// per-type health/power profile used by combatants and the damage resolver.
package battle_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DEPLOY = 2'd1,
      ST_ALIVE  = 2'd2,
      ST_DYING  = 2'd3
   } unit_state_t;

   typedef enum logic [1:0] {
      UT_NONE   = 2'd0,
      UT_LIGHT  = 2'd1,
      UT_MEDIUM = 2'd2,
      UT_HEAVY  = 2'd3
   } unit_type_t;

   // Every real type spawns at full health for the configured width.
   function automatic int unsigned profile_health(input logic [1:0] utype,
                                                  input int unsigned hp_w);
      return (utype == UT_NONE) ? 0 : ((32'd1 << hp_w) - 32'd1);
   endfunction

   // Power doubles per type: 2^(DMG_W-3), 2^(DMG_W-2), 2^(DMG_W-1).
   function automatic int unsigned profile_power(input logic [1:0] utype,
                                                 input int unsigned dmg_w);
      return (utype == UT_NONE) ? 0 : (32'd1 << (dmg_w - 32'd4 + 32'(utype)));
   endfunction

endpackage

// File: rtl/combat_unit.sv
// One lane unit slot: spawns with a typed profile, walks toward the opposing
// front, attacks on a cooldown when blocked, and holds a timed dying state.
module combat_unit
   import battle_pkg::*;
#(
   parameter int POS_W        = 9,
   parameter int HP_W         = 8,
   parameter int DMG_W        = 8,
   parameter int DIR          = 0,
   parameter int SPAWN_POS    = 0,
   parameter int ATK_COOLDOWN = 2,
   parameter int DEATH_HOLD   = 4
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             spawn_req,
   input  logic [1:0]       spawn_type,
   output logic             spawn_ack,
   input  logic             move_en,
   input  logic             damage_en,
   input  logic [DMG_W-1:0] damage_in,
   input  logic [POS_W-1:0] front_pos,
   output logic [POS_W-1:0] position,
   output logic [DMG_W-1:0] damage_out,
   output logic [1:0]       unit_type,
   output logic             alive,
   output logic             dead
);

   localparam int CD_W   = $clog2(ATK_COOLDOWN + 2);
   localparam int HOLD_W = $clog2(DEATH_HOLD + 2);
   localparam int CMP_W  = (HP_W > DMG_W) ? HP_W : DMG_W;
   localparam logic [POS_W-1:0]  POS_MAX   = '1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((DEATH_HOLD > 0) ? DEATH_HOLD - 1 : 0);

   unit_state_t      state_reg, state_next;
   logic [HP_W-1:0]  health_reg, health_next;
   logic [DMG_W-1:0] power_reg, power_next;
   logic [CD_W-1:0]  cool_reg, cool_next;
   logic [HOLD_W-1:0] hold_reg, hold_next;
   logic [POS_W-1:0] pos_reg, pos_next;
   logic [1:0]       type_reg, type_next;
   logic [DMG_W-1:0] dout_reg, dout_next;
   logic             ack_reg, ack_next;
   logic             alive_reg, alive_next;
   logic             dead_reg, dead_next;

   logic accept, lethal, path_clear, hold_done;

   assign accept     = (state_reg == ST_IDLE) && spawn_req && (spawn_type != UT_NONE);
   assign lethal     = (state_reg == ST_ALIVE) && damage_en &&
                       (CMP_W'(damage_in) >= CMP_W'(health_reg));
   assign path_clear = (DIR == 0) ? (pos_reg < front_pos) : (pos_reg > front_pos);
   assign hold_done  = (hold_reg >= HOLD_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         health_reg <= '0;
         power_reg  <= '0;
         cool_reg   <= '0;
         hold_reg   <= '0;
         pos_reg    <= '0;
         type_reg   <= '0;
         dout_reg   <= '0;
         ack_reg    <= 1'b0;
         alive_reg  <= 1'b0;
         dead_reg   <= 1'b1;
      end else begin
         state_reg  <= state_next;
         health_reg <= health_next;
         power_reg  <= power_next;
         cool_reg   <= cool_next;
         hold_reg   <= hold_next;
         pos_reg    <= pos_next;
         type_reg   <= type_next;
         dout_reg   <= dout_next;
         ack_reg    <= ack_next;
         alive_reg  <= alive_next;
         dead_reg   <= dead_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (accept) state_next = ST_DEPLOY;
         ST_DEPLOY: state_next = ST_ALIVE;
         ST_ALIVE:  if (lethal) state_next = ST_DYING;
         ST_DYING:  if (hold_done) state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // Status flags lag the state by one edge, except that a lethal hit drops alive at once.
   always_comb begin
      health_next = health_reg;
      power_next  = power_reg;
      cool_next   = cool_reg;
      hold_next   = hold_reg;
      pos_next    = pos_reg;
      type_next   = type_reg;
      dout_next   = '0;
      ack_next    = 1'b0;
      alive_next  = (state_reg == ST_ALIVE) && !lethal;
      dead_next   = (state_reg == ST_IDLE);
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               ack_next  = 1'b1;
               type_next = spawn_type;
            end
         end
         ST_DEPLOY: begin
            health_next = HP_W'(profile_health(type_reg, HP_W));
            power_next  = DMG_W'(profile_power(type_reg, DMG_W));
            pos_next    = POS_W'(SPAWN_POS);
            cool_next   = '0;
         end
         ST_ALIVE: begin
            if (lethal) begin
               health_next = '0;
               hold_next   = '0;
            end else begin
               // Non-lethal means damage_in < health, so the narrowing cannot lose bits.
               if (damage_en)
                  health_next = health_reg - HP_W'(damage_in);
               if (move_en) begin
                  if (path_clear) begin
                     if (DIR == 0)
                        pos_next = (pos_reg != POS_MAX) ? pos_reg + 1'b1 : pos_reg;
                     else
                        pos_next = (pos_reg != '0) ? pos_reg - 1'b1 : pos_reg;
                  end else if (cool_reg == '0) begin
                     dout_next = power_reg;
                     cool_next = CD_W'(ATK_COOLDOWN);
                  end else begin
                     cool_next = cool_reg - 1'b1;
                  end
               end
            end
         end
         ST_DYING: begin
            hold_next = hold_reg + 1'b1;
            if (hold_done)
               type_next = '0;
         end
         default: ;
      endcase
   end

   assign spawn_ack  = ack_reg;
   assign position   = pos_reg;
   assign damage_out = dout_reg;
   assign unit_type  = type_reg;
   assign alive      = alive_reg;
   assign dead       = dead_reg;

endmodule

// File: tb/tb_combat_unit.sv
// Bench for combat_unit: an upward and a downward instance driven together,
// checked every cycle against a plain-arithmetic model of the unit rules.
module tb_combat_unit;

   logic       clk, reset;
   logic       spawn_req, move_en, damage_en;
   logic [1:0] spawn_type;
   logic [7:0] damage_in;
   logic [8:0] front_up, front_dn;

   logic       ack_up, alive_up, dead_up, ack_dn, alive_dn, dead_dn;
   logic [8:0] pos_up, pos_dn;
   logic [7:0] dout_up, dout_dn;
   logic [1:0] type_up, type_dn;

   int checks = 0;
   int errors = 0;

   combat_unit dut_up (
      .clk(clk), .reset(reset), .spawn_req(spawn_req), .spawn_type(spawn_type),
      .spawn_ack(ack_up), .move_en(move_en), .damage_en(damage_en),
      .damage_in(damage_in), .front_pos(front_up), .position(pos_up),
      .damage_out(dout_up), .unit_type(type_up), .alive(alive_up), .dead(dead_up)
   );

   combat_unit #(.DIR(1), .SPAWN_POS(511)) dut_dn (
      .clk(clk), .reset(reset), .spawn_req(spawn_req), .spawn_type(spawn_type),
      .spawn_ack(ack_dn), .move_en(move_en), .damage_en(damage_en),
      .damage_in(damage_in), .front_pos(front_dn), .position(pos_dn),
      .damage_out(dout_dn), .unit_type(type_dn), .alive(alive_dn), .dead(dead_dn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int P_FREE = 0, P_DEPLOY = 1, P_FIGHT = 2, P_DYING = 3;

   typedef struct {
      int phase; int health; int power; int pos; int cd; int hold; int typ;
      int ack; int dout; int alive; int dead;
   } model_t;

   model_t mu, md;

   function automatic model_t model_reset();
      model_t m;
      m.phase = P_FREE; m.health = 0; m.power = 0; m.pos = 0; m.cd = 0;
      m.hold = 0; m.typ = 0; m.ack = 0; m.dout = 0; m.alive = 0; m.dead = 1;
      return m;
   endfunction

   task automatic model_step(inout model_t m, input int dir, input int spawn_pos,
                             input int front);
      int old;
      bit blocked;
      old = m.phase;
      m.ack = 0; m.dout = 0; m.alive = 0;
      m.dead = (old == P_FREE);
      case (old)
         P_FREE: if (spawn_req && spawn_type != 0) begin
            m.ack = 1; m.typ = int'(spawn_type); m.phase = P_DEPLOY;
         end
         P_DEPLOY: begin
            m.health = 255; m.power = 16 << m.typ; m.pos = spawn_pos; m.cd = 0;
            m.phase = P_FIGHT;
         end
         P_FIGHT: begin
            if (damage_en && int'(damage_in) >= m.health) begin
               m.health = 0; m.hold = 0; m.phase = P_DYING;
            end else begin
               m.alive = 1;
               if (damage_en) m.health = m.health - int'(damage_in);
               if (move_en) begin
                  blocked = (dir == 0) ? (m.pos >= front) : (m.pos <= front);
                  if (!blocked) begin
                     m.pos = m.pos + ((dir == 0) ? 1 : -1);
                     if (m.pos > 511) m.pos = 511;
                     if (m.pos < 0) m.pos = 0;
                  end else if (m.cd == 0) begin
                     m.dout = m.power; m.cd = 2;
                  end else begin
                     m.cd = m.cd - 1;
                  end
               end
            end
         end
         default: begin
            m.hold = m.hold + 1;
            if (m.hold == 4) begin
               m.phase = P_FREE; m.typ = 0;
            end
         end
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("up.ack",   32'(ack_up),   mu.ack);
      chk("up.pos",   32'(pos_up),   mu.pos);
      chk("up.dout",  32'(dout_up),  mu.dout);
      chk("up.type",  32'(type_up),  mu.typ);
      chk("up.alive", 32'(alive_up), mu.alive);
      chk("up.dead",  32'(dead_up),  mu.dead);
      chk("dn.ack",   32'(ack_dn),   md.ack);
      chk("dn.pos",   32'(pos_dn),   md.pos);
      chk("dn.dout",  32'(dout_dn),  md.dout);
      chk("dn.type",  32'(type_dn),  md.typ);
      chk("dn.alive", 32'(alive_dn), md.alive);
      chk("dn.dead",  32'(dead_dn),  md.dead);
   endtask

   task automatic cycle(input bit rq, input int ty, input bit mv, input bit de, input int dm);
      spawn_req  = rq;
      spawn_type = 2'(ty);
      move_en    = mv;
      damage_en  = de;
      damage_in  = 8'(dm);
      @(posedge clk);
      model_step(mu, 0, 0, int'(front_up));
      model_step(md, 1, 511, int'(front_dn));
      #1;
      check_all();
      $display("t=%0t rq=%0d ty=%0d mv=%0d de=%0d dm=%0d | up pos=%0d dout=%0d alive=%0d dead=%0d | dn pos=%0d dout=%0d alive=%0d dead=%0d",
               $time, rq, ty, mv, de, dm, pos_up, dout_up, alive_up, dead_up,
               pos_dn, dout_dn, alive_dn, dead_dn);
   endtask

   // Called just after an edge: asserts reset between edges and checks its immediate effect.
   task automatic pulse_reset();
      #2 reset = 1'b1;
      #1;
      mu = model_reset();
      md = model_reset();
      check_all();
      @(posedge clk);
      #1 reset = 1'b0;
      $display("t=%0t reset pulse", $time);
   endtask

   initial begin
      reset = 1'b1; spawn_req = 0; spawn_type = 0; move_en = 0; damage_en = 0;
      damage_in = 0; front_up = 9'd3; front_dn = 9'd509;
      mu = model_reset();
      md = model_reset();
      #2;
      check_all();
      @(posedge clk);
      #1 reset = 1'b0;

      // Spawn: type 0 ignored, type 2 accepted, alive two edges after the ack.
      cycle(1, 0, 0, 0, 0);
      chk("type0.noack", 32'(ack_up), 0);
      cycle(1, 2, 0, 0, 0);
      chk("spawn.ack", 32'(ack_up), 1);
      cycle(0, 0, 0, 0, 0);
      chk("deploy.alive", 32'(alive_up), 0);
      cycle(0, 0, 0, 0, 0);
      chk("spawn.alive", 32'(alive_up), 1);
      chk("spawn.type", 32'(type_up), 2);
      chk("dn.spawnpos", 32'(pos_dn), 511);
      cycle(1, 3, 0, 0, 0);
      chk("alive.noack", 32'(ack_up), 0);

      // Walk to the front and attack, then the cooldown pattern.
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 1, 0, 0);
         if (i < 3) chk("walk.pos", 32'(pos_up), 32'(i + 1));
         if (i == 3) chk("first.attack", 32'(dout_up), 64);
         if (i == 4) chk("cooldown.zero", 32'(dout_up), 0);
         if (i == 2) chk("dn.attack", 32'(dout_dn), 64);
         cycle(0, 0, 0, 0, 0);
      end
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 0);
      for (int j = 0; j < 7; j++) begin
         cycle(0, 0, 1, 0, 0);
         chk("cadence", 32'(dout_up), (j % 3 == 0) ? 64 : 0);
         cycle(0, 0, 0, 0, 0);
      end

      // Damage, then lethal hit alongside a move strobe, then the dying hold.
      cycle(0, 0, 0, 1, 100);
      cycle(0, 0, 0, 1, 100);
      cycle(0, 0, 1, 1, 55);
      chk("lethal.noatk", 32'(dout_up), 0);
      chk("lethal.alive", 32'(alive_up), 0);
      for (int k = 1; k <= 5; k++) begin
         cycle(k < 5, 1, 1, 1, 10);
         chk("dying.dead", 32'(dead_up), (k == 5) ? 1 : 0);
         if (k < 5) chk("dying.noack", 32'(ack_up), 0);
      end

      // Health boundary: 255 - 100 - 100 - 54 leaves 1, and the next 1 kills.
      cycle(1, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 100);
      cycle(0, 0, 0, 1, 100);
      cycle(0, 0, 0, 1, 54);
      chk("hp1.alive", 32'(alive_up), 1);
      cycle(0, 0, 0, 1, 1);
      chk("hp0.alive", 32'(alive_up), 0);
      for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, 0);

      // Mid-walk reset.
      front_up = 9'd20; front_dn = 9'd490;
      cycle(1, 3, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 1, 0, 0);
      pulse_reset();
      chk("reset.pos", 32'(pos_up), 0);

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 49) == 0) front_up = 9'($urandom_range(0, 12));
         if ($urandom_range(0, 49) == 0) front_dn = 9'($urandom_range(499, 511));
         if ($urandom_range(0, 249) == 0) pulse_reset();
         cycle($urandom_range(0, 7) == 0, int'($urandom_range(0, 3)),
               $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
               ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 60)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
